// File: rtl/mmc1_pkg.sv
// Shared constants and types for the synchronous MMC1 mapper: register
// select codes, reset values, banking mode enums and the M2 capture record.
package mmc1_pkg;

    localparam logic [1:0] REG_CTRL = 2'b00;
    localparam logic [1:0] REG_CHR0 = 2'b01;
    localparam logic [1:0] REG_CHR1 = 2'b10;
    localparam logic [1:0] REG_PRG  = 2'b11;

    localparam logic [4:0] SHIFT_INIT = 5'b10000;
    localparam logic [4:0] CTRL_INIT  = 5'b01100;

    typedef enum logic [1:0] {
        MIR_ONE_LO = 2'b00,
        MIR_ONE_HI = 2'b01,
        MIR_VERT   = 2'b10,
        MIR_HORIZ  = 2'b11
    } mirror_e;

    typedef enum logic [1:0] {
        PRG_32K_A     = 2'b00,
        PRG_32K_B     = 2'b01,
        PRG_FIX_FIRST = 2'b10,
        PRG_FIX_LAST  = 2'b11
    } prg_mode_e;

    typedef struct packed {
        logic romsel;
        logic rw;
        logic a14;
        logic a13;
        logic d7;
        logic d0;
    } capture_t;

    localparam capture_t CAPTURE_INIT = '0;

endpackage

// File: rtl/mmc1_sync_mapper_if.sv
// Cartridge-edge signal bundle: CPU/PPU pins into the mapper and the
// banking outputs back to the ROM/RAM chips.
interface mmc1_sync_mapper_if #(
    parameter int PRG_BANK_BITS  = 4,
    parameter int CHR_BANK_BITS  = 5,
    parameter int WRAM_BANK_BITS = 0
);
    localparam int WRAM_A_W = (WRAM_BANK_BITS > 0) ? WRAM_BANK_BITS : 1;

    logic                     CPU_M2;
    logic                     nCPU_ROMSEL;
    logic                     nCPU_RW;
    logic                     CPU_A14;
    logic                     CPU_A13;
    logic                     CPU_D7;
    logic                     CPU_D0;
    logic                     PPU_A12;
    logic                     PPU_A11;
    logic                     PPU_A10;
    logic                     CIRAM_A10;
    logic [PRG_BANK_BITS-1:0] PRG_A;
    logic                     nPRG_CE;
    logic                     WRAM_CE;
    logic [WRAM_A_W-1:0]      WRAM_A;
    logic [CHR_BANK_BITS-1:0] CHR_A;

    modport master (
        output CPU_M2, nCPU_ROMSEL, nCPU_RW, CPU_A14, CPU_A13, CPU_D7, CPU_D0,
        output PPU_A12, PPU_A11, PPU_A10,
        input  CIRAM_A10, PRG_A, nPRG_CE, WRAM_CE, WRAM_A, CHR_A
    );

    modport slave (
        input  CPU_M2, nCPU_ROMSEL, nCPU_RW, CPU_A14, CPU_A13, CPU_D7, CPU_D0,
        input  PPU_A12, PPU_A11, PPU_A10,
        output CIRAM_A10, PRG_A, nPRG_CE, WRAM_CE, WRAM_A, CHR_A
    );

endinterface

// File: rtl/mmc1_m2_sync.sv
// Brings CPU_M2 into the board clock domain, flags its falling edge and
// holds the bus pins as last seen while M2 was high.
module mmc1_m2_sync
    import mmc1_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     i_m2,
    input  logic     i_romsel,
    input  logic     i_rw,
    input  logic     i_a14,
    input  logic     i_a13,
    input  logic     i_d7,
    input  logic     i_d0,
    output logic     o_fall,
    output capture_t o_cap
);

    logic     r_m2_meta;
    logic     r_m2_s;
    logic     r_m2_d;
    logic     r_armed;
    capture_t r_cap;

    // The M2 pipeline resets high and stays disarmed until M2 has been seen
    // low, so a CPU cycle that straddles reset release never commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m2_meta <= 1'b1;
            r_m2_s    <= 1'b1;
            r_m2_d    <= 1'b1;
            r_armed   <= 1'b0;
            r_cap     <= CAPTURE_INIT;
        end else begin
            r_m2_meta <= i_m2;
            r_m2_s    <= r_m2_meta;
            r_m2_d    <= r_m2_s;
            if (!r_m2_s && !r_m2_d) begin
                r_armed <= 1'b1;
            end
            if (r_m2_s) begin
                r_cap <= {i_romsel, i_rw, i_a14, i_a13, i_d7, i_d0};
            end
        end
    end

    assign o_fall = r_m2_d & ~r_m2_s & r_armed;
    assign o_cap  = r_cap;

endmodule

// File: rtl/mmc1_sync_mapper.sv
// MMC1-compatible mapper clocked from the board clock: serial register
// loader with RMW write filter, plus combinational PRG/CHR/WRAM banking.
module mmc1_sync_mapper
    import mmc1_pkg::*;
#(
    parameter int PRG_BANK_BITS  = 4,
    parameter int CHR_BANK_BITS  = 5,
    parameter int WRAM_BANK_BITS = 0,
    parameter int WRAM_DIS_EN    = 1
) (
    input  logic               CLK,
    input  logic               RST,
    mmc1_sync_mapper_if.slave  bus
);

    capture_t  w_cap;
    logic      w_fall;
    logic      w_wr;
    logic      w_accept;
    logic [4:0] w_shifted;

    logic [4:0] r_shift;
    logic [4:0] r_ctrl;
    logic [4:0] r_chr0;
    logic [4:0] r_chr1;
    logic [4:0] r_prg;
    logic       r_prev_wr;

    mmc1_m2_sync u_m2_sync (
        .clk      (CLK),
        .rst      (RST),
        .i_m2     (bus.CPU_M2),
        .i_romsel (bus.nCPU_ROMSEL),
        .i_rw     (bus.nCPU_RW),
        .i_a14    (bus.CPU_A14),
        .i_a13    (bus.CPU_A13),
        .i_d7     (bus.CPU_D7),
        .i_d0     (bus.CPU_D0),
        .o_fall   (w_fall),
        .o_cap    (w_cap)
    );

    assign w_wr      = ~w_cap.romsel & ~w_cap.rw;
    // Only the first of back-to-back writes counts (RMW double write).
    assign w_accept  = w_fall & w_wr & ~r_prev_wr;
    assign w_shifted = {w_cap.d0, r_shift[4:1]};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_shift   <= SHIFT_INIT;
            r_ctrl    <= CTRL_INIT;
            r_chr0    <= '0;
            r_chr1    <= '0;
            r_prg     <= '0;
            r_prev_wr <= 1'b0;
        end else begin
            if (w_fall) begin
                r_prev_wr <= w_wr;
            end
            if (w_accept) begin
                if (w_cap.d7) begin
                    r_shift <= SHIFT_INIT;
                    r_ctrl  <= r_ctrl | CTRL_INIT;
                end else if (!r_shift[0]) begin
                    r_shift <= w_shifted;
                end else begin
                    // Marker bit reached bit 0: this is the fifth write.
                    r_shift <= SHIFT_INIT;
                    case ({w_cap.a14, w_cap.a13})
                        REG_CTRL: r_ctrl <= w_shifted;
                        REG_CHR0: r_chr0 <= w_shifted;
                        REG_CHR1: r_chr1 <= w_shifted;
                        REG_PRG:  r_prg  <= w_shifted;
                        default:  ;
                    endcase
                end
            end
        end
    end

    mirror_e    w_mir;
    prg_mode_e  w_pmode;
    logic [3:0] w_b;
    logic [3:0] w_bank16;
    logic [4:0] w_chr_full;

    assign w_mir   = mirror_e'(r_ctrl[1:0]);
    assign w_pmode = prg_mode_e'(r_ctrl[3:2]);
    assign w_b     = r_prg[3:0];

    always_comb begin
        bus.CIRAM_A10 = 1'b0;
        unique case (w_mir)
            MIR_ONE_LO: bus.CIRAM_A10 = 1'b0;
            MIR_ONE_HI: bus.CIRAM_A10 = 1'b1;
            MIR_VERT:   bus.CIRAM_A10 = bus.PPU_A10;
            MIR_HORIZ:  bus.CIRAM_A10 = bus.PPU_A11;
            default:    bus.CIRAM_A10 = 1'b0;
        endcase
    end

    always_comb begin
        w_bank16 = w_b;
        unique case (w_pmode)
            PRG_32K_A, PRG_32K_B: w_bank16 = {w_b[3:1], bus.CPU_A14};
            PRG_FIX_FIRST:        w_bank16 = bus.CPU_A14 ? w_b : 4'h0;
            PRG_FIX_LAST:         w_bank16 = bus.CPU_A14 ? 4'hF : w_b;
            default:              w_bank16 = w_b;
        endcase
    end

    always_comb begin
        if (r_ctrl[4]) begin
            w_chr_full = bus.PPU_A12 ? r_chr1 : r_chr0;
        end else begin
            w_chr_full = {r_chr0[4:1], bus.PPU_A12};
        end
    end

    // On 512 KB boards the outer 256 KB half comes from chr0 bit 4, even for
    // the fixed banks.
    generate
        if (PRG_BANK_BITS == 5) begin : g_prg_512k
            assign bus.PRG_A = {r_chr0[4], w_bank16};
        end else begin : g_prg_256k
            assign bus.PRG_A = w_bank16[PRG_BANK_BITS-1:0];
        end
    endgenerate

    generate
        if (WRAM_BANK_BITS == 0) begin : g_wram_flat
            assign bus.WRAM_A = '0;
        end else begin : g_wram_banked
            assign bus.WRAM_A = r_chr0[2 +: WRAM_BANK_BITS];
        end
    endgenerate

    assign bus.CHR_A   = w_chr_full[CHR_BANK_BITS-1:0];
    assign bus.nPRG_CE = bus.nCPU_ROMSEL | ~bus.nCPU_RW;
    assign bus.WRAM_CE = bus.CPU_M2 & bus.nCPU_ROMSEL & bus.CPU_A14 & bus.CPU_A13
                       & ~((WRAM_DIS_EN != 0) & r_prg[4]);

endmodule

// File: tb/tb_mmc1_sync_mapper.sv
// Drives two mapper configurations (SNROM-like and SUROM/SOROM-like) with
// the same CPU bus traffic and compares their pins to a behavioural model.
`timescale 1ns/1ps
module tb_mmc1_sync_mapper;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mmc1_sync_mapper_if #(.PRG_BANK_BITS(4), .CHR_BANK_BITS(5), .WRAM_BANK_BITS(0)) ia ();
    mmc1_sync_mapper_if #(.PRG_BANK_BITS(5), .CHR_BANK_BITS(4), .WRAM_BANK_BITS(2)) ib ();

    mmc1_sync_mapper #(.PRG_BANK_BITS(4), .CHR_BANK_BITS(5), .WRAM_BANK_BITS(0), .WRAM_DIS_EN(1))
        dut_a (.CLK(clk), .RST(rst), .bus(ia));
    mmc1_sync_mapper #(.PRG_BANK_BITS(5), .CHR_BANK_BITS(4), .WRAM_BANK_BITS(2), .WRAM_DIS_EN(0))
        dut_b (.CLK(clk), .RST(rst), .bus(ib));

    int n_checks = 0;
    int n_err    = 0;

    // Reference register file: plain integers, shift tracked as a count.
    int m_ctrl, m_chr0, m_chr1, m_prg, m_cnt, m_val;
    bit m_prev;

    // Pin vector: [0]=M2 [1]=ROMSEL [2]=RW [3]=A14 [4]=A13 [5]=D7 [6]=D0
    //             [7]=PPU_A12 [8]=PPU_A11 [9]=PPU_A10
    localparam logic [9:0] PINS_IDLE = 10'b00_0000_0110;

    function automatic logic [9:0] mk(input bit m2, input bit romsel, input bit rw,
                                      input bit a14, input bit a13,
                                      input bit p12, input bit p11, input bit p10);
        return {p10, p11, p12, 1'b0, 1'b0, a13, a14, rw, romsel, m2};
    endfunction

    task automatic set_pins(input logic [9:0] p);
        ia.CPU_M2 = p[0]; ia.nCPU_ROMSEL = p[1]; ia.nCPU_RW = p[2];
        ia.CPU_A14 = p[3]; ia.CPU_A13 = p[4]; ia.CPU_D7 = p[5]; ia.CPU_D0 = p[6];
        ia.PPU_A12 = p[7]; ia.PPU_A11 = p[8]; ia.PPU_A10 = p[9];
        ib.CPU_M2 = p[0]; ib.nCPU_ROMSEL = p[1]; ib.nCPU_RW = p[2];
        ib.CPU_A14 = p[3]; ib.CPU_A13 = p[4]; ib.CPU_D7 = p[5]; ib.CPU_D0 = p[6];
        ib.PPU_A12 = p[7]; ib.PPU_A11 = p[8]; ib.PPU_A10 = p[9];
    endtask

    task automatic set_m2(input bit v);
        ia.CPU_M2 = v;
        ib.CPU_M2 = v;
    endtask

    task automatic model_reset();
        m_ctrl = 12; m_chr0 = 0; m_chr1 = 0; m_prg = 0;
        m_cnt = 0; m_val = 0; m_prev = 1'b0;
    endtask

    task automatic model_fall(input bit romsel, input bit rw, input bit a14, input bit a13,
                              input bit d7, input bit d0);
        bit wr;
        wr = !romsel && !rw;
        if (wr && !m_prev) begin
            if (d7) begin
                m_cnt = 0; m_val = 0;
                m_ctrl = m_ctrl | 12;
            end else begin
                m_val = m_val + ((d0 ? 1 : 0) << m_cnt);
                m_cnt = m_cnt + 1;
                if (m_cnt == 5) begin
                    case ({a14, a13})
                        2'b00:   m_ctrl = m_val;
                        2'b01:   m_chr0 = m_val;
                        2'b10:   m_chr1 = m_val;
                        default: m_prg  = m_val;
                    endcase
                    m_cnt = 0; m_val = 0;
                end
            end
        end
        m_prev = wr;
    endtask

    function automatic logic [14:0] exp_out(input int pb, input int cb, input int wb,
                                            input bit dis, input logic [9:0] p);
        logic cir, nce, wce;
        int b, bank, chr, wa, mode;
        case (m_ctrl % 4)
            0:       cir = 1'b0;
            1:       cir = 1'b1;
            2:       cir = p[9];
            default: cir = p[8];
        endcase
        b = m_prg % 16;
        mode = (m_ctrl / 4) % 4;
        if (mode < 2)       bank = (b / 2) * 2 + (p[3] ? 1 : 0);
        else if (mode == 2) bank = p[3] ? b : 0;
        else                bank = p[3] ? 15 : b;
        if (pb == 5 && m_chr0 >= 16) bank = bank + 16;
        bank = bank % (1 << pb);
        if (m_ctrl >= 16) chr = p[7] ? m_chr1 : m_chr0;
        else              chr = (m_chr0 / 2) * 2 + (p[7] ? 1 : 0);
        chr = chr % (1 << cb);
        wa = (wb == 0) ? 0 : (m_chr0 / 4) % (1 << wb);
        nce = p[1] | ~p[2];
        wce = p[0] & p[1] & p[3] & p[4] & ~(dis & (m_prg >= 16));
        return {cir, 5'(bank), nce, wce, 2'(wa), 5'(chr)};
    endfunction

    function automatic logic [14:0] act_a();
        return {ia.CIRAM_A10, 1'b0, ia.PRG_A, ia.nPRG_CE, ia.WRAM_CE, 1'b0, ia.WRAM_A, ia.CHR_A};
    endfunction

    function automatic logic [14:0] act_b();
        return {ib.CIRAM_A10, ib.PRG_A, ib.nPRG_CE, ib.WRAM_CE, ib.WRAM_A, 1'b0, ib.CHR_A};
    endfunction

    // One full M2 period; the model sees the write once the period is over.
    task automatic cpu_cycle(input bit romsel, input bit rw, input bit a14, input bit a13,
                             input bit d7, input bit d0);
        @(negedge clk);
        set_pins({3'b000, d0, d7, a13, a14, rw, romsel, 1'b0});
        repeat (2) @(negedge clk);
        set_m2(1'b1);
        repeat (8) @(negedge clk);
        set_m2(1'b0);
        repeat (8) @(negedge clk);
        model_fall(romsel, rw, a14, a13, d7, d0);
    endtask

    task automatic cpu_write(input bit a14, input bit a13, input bit d7, input bit d0);
        cpu_cycle(1'b0, 1'b0, a14, a13, d7, d0);
    endtask

    task automatic cpu_idle();
        cpu_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic load_reg(input logic [1:0] sel, input logic [4:0] val);
        for (int i = 0; i < 5; i++) begin
            cpu_write(sel[1], sel[0], 1'b0, val[i]);
            cpu_idle();
        end
    endtask

    // Pins change only between a falling and the next rising edge, so probing
    // never looks like an M2 cycle to the synchroniser.
    task automatic probe(input logic [9:0] p);
        @(negedge clk);
        set_pins(p);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_pins(PINS_IDLE);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        probe(mk(1, 0, 1, 1, 0, 0, 1, 1));
        n_checks += 4;
        if (ia.PRG_A !== 4'hF) begin n_err++; $display("FAIL reset_c000_a: got %b want 1111", ia.PRG_A); end
        if (ib.PRG_A !== 5'h0F) begin n_err++; $display("FAIL reset_c000_b: got %b want 01111", ib.PRG_A); end
        if (ia.CIRAM_A10 !== 1'b0) begin n_err++; $display("FAIL reset_ciram: got %b want 0", ia.CIRAM_A10); end
        if (ia.nPRG_CE !== 1'b0) begin n_err++; $display("FAIL reset_prg_ce: got %b want 0", ia.nPRG_CE); end
        set_pins(PINS_IDLE);
        probe(mk(1, 0, 1, 0, 0, 0, 0, 0));
        n_checks += 2;
        if (ia.PRG_A !== 4'h0) begin n_err++; $display("FAIL reset_8000_a: got %b want 0000", ia.PRG_A); end
        if (ib.PRG_A !== 5'h00) begin n_err++; $display("FAIL reset_8000_b: got %b want 00000", ib.PRG_A); end
        set_pins(PINS_IDLE);
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                logic [9:0] r;
                r = 10'($urandom);
                set_pins(r);
                #1;
                n_checks += 2;
                if (act_a() !== exp_out(4, 5, 0, 1'b1, r)) begin n_err++; $display("FAIL reset_pins_a: pins=%b got %b want %b", r, act_a(), exp_out(4, 5, 0, 1'b1, r)); end
                if (act_b() !== exp_out(5, 4, 2, 1'b0, r)) begin n_err++; $display("FAIL reset_pins_b: pins=%b got %b want %b", r, act_b(), exp_out(5, 4, 2, 1'b0, r)); end
            end
            set_pins(PINS_IDLE);
        end
    endtask

    task automatic test_serial_load();
        load_reg(2'b11, 5'b00101);
        probe(mk(1, 0, 1, 0, 0, 0, 0, 0));
        n_checks += 2;
        if (ia.PRG_A !== 4'b0101) begin n_err++; $display("FAIL serial_8000_a: got %b want 0101", ia.PRG_A); end
        if (ib.PRG_A !== 5'b00101) begin n_err++; $display("FAIL serial_8000_b: got %b want 00101", ib.PRG_A); end
        set_pins(PINS_IDLE);
        probe(mk(1, 0, 1, 1, 0, 0, 0, 0));
        n_checks += 1;
        if (ia.PRG_A !== 4'hF) begin n_err++; $display("FAIL serial_c000_a: got %b want 1111", ia.PRG_A); end
        set_pins(PINS_IDLE);
    endtask

    task automatic test_rmw_filter();
        do_reset();
        cpu_write(1, 1, 0, 1);
        cpu_write(1, 1, 0, 0);
        cpu_idle();
        cpu_write(1, 1, 0, 1);
        cpu_write(1, 1, 1, 0);
        cpu_idle();
        cpu_write(1, 1, 0, 0); cpu_idle();
        cpu_write(1, 1, 0, 0); cpu_idle();
        cpu_write(1, 1, 0, 1); cpu_idle();
        probe(mk(1, 0, 1, 0, 0, 0, 0, 0));
        n_checks += 2;
        if (ia.PRG_A !== 4'b0011) begin n_err++; $display("FAIL rmw_8000_a: got %b want 0011", ia.PRG_A); end
        if (ib.PRG_A !== 5'b00011) begin n_err++; $display("FAIL rmw_8000_b: got %b want 00011", ib.PRG_A); end
        set_pins(PINS_IDLE);
        probe(mk(1, 1, 1, 1, 1, 0, 0, 0));
        n_checks += 2;
        if (ia.WRAM_CE !== 1'b0) begin n_err++; $display("FAIL rmw_wram_dis_a: got %b want 0", ia.WRAM_CE); end
        if (ib.WRAM_CE !== 1'b1) begin n_err++; $display("FAIL rmw_wram_nodis_b: got %b want 1", ib.WRAM_CE); end
        set_pins(PINS_IDLE);
    endtask

    task automatic test_reset_bit();
        do_reset();
        load_reg(2'b10, 5'b10110);
        load_reg(2'b01, 5'b01001);
        load_reg(2'b00, 5'b00000);
        load_reg(2'b11, 5'b00101);
        probe(mk(1, 0, 1, 1, 0, 0, 0, 0));
        n_checks += 1;
        if (ia.PRG_A !== 4'b0101) begin n_err++; $display("FAIL rbit_32k_c000: got %b want 0101", ia.PRG_A); end
        set_pins(PINS_IDLE);
        for (int i = 0; i < 3; i++) begin
            cpu_write(0, 0, 0, 1);
            cpu_idle();
        end
        cpu_write(0, 0, 1, 0);
        cpu_idle();
        probe(mk(1, 0, 1, 1, 0, 0, 1, 1));
        n_checks += 2;
        if (ia.PRG_A !== 4'hF) begin n_err++; $display("FAIL rbit_mode3_c000: got %b want 1111", ia.PRG_A); end
        if (ia.CIRAM_A10 !== 1'b0) begin n_err++; $display("FAIL rbit_mirror_kept: got %b want 0", ia.CIRAM_A10); end
        set_pins(PINS_IDLE);
        load_reg(2'b00, 5'b10010);
        probe(mk(0, 1, 1, 0, 0, 1, 0, 1));
        n_checks += 3;
        if (ia.CIRAM_A10 !== 1'b1) begin n_err++; $display("FAIL rbit_vert_hi: got %b want 1", ia.CIRAM_A10); end
        if (ia.CHR_A !== 5'b10110) begin n_err++; $display("FAIL rbit_chr1_a: got %b want 10110", ia.CHR_A); end
        if (ib.CHR_A !== 4'b0110) begin n_err++; $display("FAIL rbit_chr1_b: got %b want 0110", ib.CHR_A); end
        set_pins(PINS_IDLE);
        probe(mk(0, 1, 1, 0, 0, 0, 1, 0));
        n_checks += 2;
        if (ia.CIRAM_A10 !== 1'b0) begin n_err++; $display("FAIL rbit_vert_lo: got %b want 0", ia.CIRAM_A10); end
        if (ia.CHR_A !== 5'b01001) begin n_err++; $display("FAIL rbit_chr0_a: got %b want 01001", ia.CHR_A); end
        set_pins(PINS_IDLE);
    endtask

    task automatic test_surom();
        do_reset();
        load_reg(2'b01, 5'b10000);
        load_reg(2'b11, 5'b00011);
        probe(mk(1, 0, 1, 0, 0, 0, 0, 0));
        n_checks += 1;
        if (ib.PRG_A !== 5'b10011) begin n_err++; $display("FAIL surom_8000: got %b want 10011", ib.PRG_A); end
        set_pins(PINS_IDLE);
        probe(mk(1, 0, 1, 1, 0, 0, 0, 0));
        n_checks += 2;
        if (ib.PRG_A !== 5'b11111) begin n_err++; $display("FAIL surom_c000: got %b want 11111", ib.PRG_A); end
        if (ia.PRG_A !== 4'hF) begin n_err++; $display("FAIL surom_c000_a: got %b want 1111", ia.PRG_A); end
        set_pins(PINS_IDLE);
        load_reg(2'b01, 5'b01000);
        probe(mk(1, 1, 1, 1, 1, 0, 0, 0));
        n_checks += 2;
        if (ib.WRAM_A !== 2'b10) begin n_err++; $display("FAIL wram_bank: got %b want 10", ib.WRAM_A); end
        if (ia.WRAM_CE !== 1'b1) begin n_err++; $display("FAIL wram_en: got %b want 1", ia.WRAM_CE); end
        set_pins(PINS_IDLE);
    endtask

    task automatic test_mid_write_reset();
        load_reg(2'b00, 5'b00011);
        @(negedge clk);
        set_pins({3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        repeat (2) @(negedge clk);
        set_m2(1'b1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        set_m2(1'b0);
        repeat (8) @(negedge clk);
        cpu_write(1, 1, 0, 0); cpu_idle();
        cpu_write(1, 1, 0, 1); cpu_idle();
        cpu_write(1, 1, 0, 0); cpu_idle();
        cpu_write(1, 1, 0, 0); cpu_idle();
        probe(mk(1, 0, 1, 0, 0, 0, 1, 0));
        n_checks += 2;
        if (ia.PRG_A !== 4'h0) begin n_err++; $display("FAIL midrst_no_commit: got %b want 0000", ia.PRG_A); end
        if (ia.CIRAM_A10 !== 1'b0) begin n_err++; $display("FAIL midrst_ctrl_reset: got %b want 0", ia.CIRAM_A10); end
        set_pins(PINS_IDLE);
        cpu_write(1, 1, 0, 1); cpu_idle();
        probe(mk(1, 0, 1, 0, 0, 0, 0, 0));
        n_checks += 1;
        if (ia.PRG_A !== 4'b0010) begin n_err++; $display("FAIL midrst_fifth: got %b want 0010", ia.PRG_A); end
        set_pins(PINS_IDLE);
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 80; c++) begin
            logic [31:0] r;
            r = $urandom;
            if (r[1:0] == 2'b00) cpu_idle();
            else cpu_write(r[2], r[3], (r[8:5] == 4'h0), r[4]);
            if (c % 4 == 3) begin
                @(negedge clk);
                for (int k = 0; k < 3; k++) begin
                    logic [9:0] p;
                    p = 10'($urandom);
                    set_pins(p);
                    #1;
                    n_checks += 2;
                    if (act_a() !== exp_out(4, 5, 0, 1'b1, p)) begin n_err++; $display("FAIL random_a: cyc=%0d pins=%b got %b want %b", c, p, act_a(), exp_out(4, 5, 0, 1'b1, p)); end
                    if (act_b() !== exp_out(5, 4, 2, 1'b0, p)) begin n_err++; $display("FAIL random_b: cyc=%0d pins=%b got %b want %b", c, p, act_b(), exp_out(5, 4, 2, 1'b0, p)); end
                end
                set_pins(PINS_IDLE);
            end
        end
    endtask

    initial begin
        set_pins(PINS_IDLE);
        model_reset();
        test_reset();
        $display("test_reset done: checks=%0d errors=%0d", n_checks, n_err);
        test_serial_load();
        $display("test_serial_load done: checks=%0d errors=%0d", n_checks, n_err);
        test_rmw_filter();
        $display("test_rmw_filter done: checks=%0d errors=%0d", n_checks, n_err);
        test_reset_bit();
        $display("test_reset_bit done: checks=%0d errors=%0d", n_checks, n_err);
        test_surom();
        $display("test_surom done: checks=%0d errors=%0d", n_checks, n_err);
        test_mid_write_reset();
        $display("test_mid_write_reset done: checks=%0d errors=%0d", n_checks, n_err);
        test_random();
        $display("test_random done: checks=%0d errors=%0d", n_checks, n_err);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
